// File: rtl/ascon_pkg.sv
// Shared definitions for the serial Ascon hash host and the core wrapper.
// Holds the host FSM state encoding, the default message/digest widths and a
// small max helper used to size the start-strobe schedule.
package ascon_pkg;

  localparam int unsigned DefaultY       = 40;
  localparam int unsigned DefaultL       = 256;
  localparam int unsigned DefaultTimeout = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StShift,
    StWait,
    StStart,
    StCollect,
    StDone
  } host_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serdes_shift_reg.sv
// Serializer/deserializer storage for the hash host.
// TX side: a TxW-bit register loaded in parallel and shifted left, MSB exposed.
// RX side: an RxW-bit register cleared in one cycle and written one bit at a
// time at an arbitrary index.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   i_load         load i_load_data into the TX register (wins over i_shift)
//   i_shift        shift the TX register left by one, zero fill
//   o_tx_msb       current TX MSB
//   i_clr          clear the RX register (wins over i_cap)
//   i_cap          write i_cap_bit into RX bit i_cap_idx
//   o_rx_data      RX register contents
module serdes_shift_reg #(
  parameter int unsigned TxW  = 40,
  parameter int unsigned RxW  = 256,
  parameter int unsigned IdxW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [TxW-1:0]  i_load_data,
  input  logic            i_shift,
  output logic            o_tx_msb,
  input  logic            i_clr,
  input  logic            i_cap,
  input  logic [IdxW-1:0] i_cap_idx,
  input  logic            i_cap_bit,
  output logic [RxW-1:0]  o_rx_data
);

  logic [TxW-1:0] r_tx;
  logic [RxW-1:0] r_rx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_load_data;
      end else if (i_shift) begin
        r_tx <= {r_tx[TxW-2:0], 1'b0};
      end
      if (i_clr) begin
        r_rx <= '0;
      end else if (i_cap) begin
        r_rx[i_cap_idx] <= i_cap_bit;
      end
    end
  end

  assign o_tx_msb  = r_tx[TxW-1];
  assign o_rx_data = r_rx;

endmodule

// File: rtl/hash_serial_host.sv
// Host-side driver for the bit-serial Ascon hash core.
// Takes a Y-bit message over valid/ready, resets the core, streams the message
// MSB-first, pulses core_start when the core is due, collects the L-bit digest
// LSB-first and hands it back over valid/ready (with a timeout flag).
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   req_valid/req_ready         message handshake; msg_data bit Y-1 is sent first
//   digest_valid/digest_ready   result handshake; digest_data bit 0 = first serial bit
//   timeout_err                 qualifies digest_valid; 1 = core never responded
//   core_rst_n/core_msg/core_start   registered outputs to the core
//   core_digest/core_hash_ready      serial digest stream from the core
module hash_serial_host
  import ascon_pkg::*;
#(
  parameter int unsigned Y       = DefaultY,
  parameter int unsigned L       = DefaultL,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [Y-1:0] msg_data,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [L-1:0] digest_data,
  output logic         timeout_err,
  output logic         core_rst_n,
  output logic         core_msg,
  output logic         core_start,
  input  logic         core_digest,
  input  logic         core_hash_ready
);

  localparam int unsigned M  = max3(Y, L, 64);
  localparam int unsigned KW = $clog2(L + 1);
  localparam int unsigned IW = (L > 1) ? $clog2(L) : 1;

  host_state_e   r_state, w_state_nxt;
  logic [31:0]   r_cnt, w_cnt_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic          r_hr_dly, w_hr_dly_nxt;
  logic          r_seen, w_seen_nxt;
  logic          r_digest_valid, w_digest_valid_nxt;
  logic          r_timeout_err, w_timeout_err_nxt;
  logic          r_core_rst_n, w_core_rst_n_nxt;
  logic          r_core_msg, w_core_msg_nxt;
  logic          r_core_start, w_core_start_nxt;
  logic          w_load, w_shift, w_clr, w_cap, w_tx_bit;

  serdes_shift_reg #(
    .TxW (Y),
    .RxW (L),
    .IdxW(IW)
  ) u_serdes (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_data(msg_data),
    .i_shift    (w_shift),
    .o_tx_msb   (w_tx_bit),
    .i_clr      (w_clr),
    .i_cap      (w_cap),
    .i_cap_idx  (r_k[IW-1:0]),
    .i_cap_bit  (core_digest),
    .o_rx_data  (digest_data)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_k_nxt            = r_k;
    w_hr_dly_nxt       = 1'b0;
    w_seen_nxt         = r_seen;
    w_digest_valid_nxt = r_digest_valid;
    w_timeout_err_nxt  = r_timeout_err;
    w_load             = 1'b0;
    w_clr              = 1'b0;
    w_cap              = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_load            = 1'b1;
          w_clr             = 1'b1;
          w_k_nxt           = '0;
          w_timeout_err_nxt = 1'b0;
          w_state_nxt       = StCrst;
        end
      end
      StCrst: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StShift;
      end
      StShift: begin
        w_cnt_nxt = r_cnt + 1;
        if (r_cnt == 32'(Y - 1)) w_state_nxt = StWait;
      end
      StWait: begin
        // Leaving with cnt = M+1, which is the START cycle.
        w_cnt_nxt = r_cnt + 1;
        if (r_cnt == 32'(M)) w_state_nxt = StStart;
      end
      StStart: begin
        w_cnt_nxt   = '0;
        w_seen_nxt  = 1'b0;
        w_state_nxt = StCollect;
      end
      StCollect: begin
        // The core's digest bit lags its ready flag by one cycle.
        w_hr_dly_nxt = core_hash_ready;
        if (core_hash_ready) w_seen_nxt = 1'b1;
        // r_cnt doubles as the timeout counter; it freezes once the core answers.
        if (!r_seen && !core_hash_ready) w_cnt_nxt = r_cnt + 1;
        if (r_hr_dly) begin
          w_cap   = 1'b1;
          w_k_nxt = r_k + KW'(1);
          if (r_k == KW'(L - 1)) begin
            w_digest_valid_nxt = 1'b1;
            w_timeout_err_nxt  = 1'b0;
            w_state_nxt        = StDone;
          end
        end else if (!r_seen && !core_hash_ready && r_cnt == 32'(TIMEOUT - 1)) begin
          w_digest_valid_nxt = 1'b1;
          w_timeout_err_nxt  = 1'b1;
          w_state_nxt        = StDone;
        end
      end
      StDone: begin
        if (digest_ready) begin
          w_digest_valid_nxt = 1'b0;
          w_state_nxt        = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Core-facing outputs are registered against the state being entered.
    w_shift          = (w_state_nxt == StShift);
    w_core_msg_nxt   = w_shift ? w_tx_bit : 1'b0;
    w_core_start_nxt = (w_state_nxt == StStart);
    w_core_rst_n_nxt = (w_state_nxt inside {StShift, StWait, StStart, StCollect});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_k            <= '0;
      r_hr_dly       <= 1'b0;
      r_seen         <= 1'b0;
      r_digest_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_core_msg     <= 1'b0;
      r_core_start   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_k            <= w_k_nxt;
      r_hr_dly       <= w_hr_dly_nxt;
      r_seen         <= w_seen_nxt;
      r_digest_valid <= w_digest_valid_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_core_rst_n   <= w_core_rst_n_nxt;
      r_core_msg     <= w_core_msg_nxt;
      r_core_start   <= w_core_start_nxt;
    end
  end

  assign req_ready    = (r_state == StIdle);
  assign digest_valid = r_digest_valid;
  assign timeout_err  = r_timeout_err;
  assign core_rst_n   = r_core_rst_n;
  assign core_msg     = r_core_msg;
  assign core_start   = r_core_start;

endmodule

// File: tb/tb_hash_serial_host.sv
// Bench for hash_serial_host: a behavioural serial core drives the main DUT
// (Y=40, L=256, TIMEOUT=50); a second DUT (Y=300) checks start-strobe timing.
module tb_hash_serial_host;

  localparam int unsigned Y = 40;
  localparam int unsigned L = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [Y-1:0] msg_data = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [L-1:0] digest_data;
  logic         timeout_err;
  logic         core_rst_n, core_msg, core_start;
  logic         core_digest = 1'b0;
  logic         core_hash_ready = 1'b0;

  hash_serial_host #(.Y(Y), .L(L), .TIMEOUT(50)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .msg_data       (msg_data),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .digest_data    (digest_data),
    .timeout_err    (timeout_err),
    .core_rst_n     (core_rst_n),
    .core_msg       (core_msg),
    .core_start     (core_start),
    .core_digest    (core_digest),
    .core_hash_ready(core_hash_ready)
  );

  // Wide-message DUT
  logic           req_valid_b = 1'b0;
  logic           req_ready_b;
  logic [299:0]   msg_data_b = '1;
  logic           digest_valid_b;
  logic           digest_ready_b = 1'b0;
  logic [L-1:0]   digest_data_b;
  logic           timeout_err_b;
  logic           core_rst_n_b, core_msg_b, core_start_b;
  logic           core_digest_b = 1'b0;
  logic           core_hash_ready_b = 1'b0;

  hash_serial_host #(.Y(300), .L(L), .TIMEOUT(20)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid_b),
    .req_ready      (req_ready_b),
    .msg_data       (msg_data_b),
    .digest_valid   (digest_valid_b),
    .digest_ready   (digest_ready_b),
    .digest_data    (digest_data_b),
    .timeout_err    (timeout_err_b),
    .core_rst_n     (core_rst_n_b),
    .core_msg       (core_msg_b),
    .core_start     (core_start_b),
    .core_digest    (core_digest_b),
    .core_hash_ready(core_hash_ready_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Behavioural core: latches the serial message, streams golden LSB-first
  // starting 10 cycles after core_start, digest bit one cycle after ready.
  logic [L-1:0] golden = '0;
  logic [Y-1:0] lat = '0;
  bit respond = 1'b1;
  bit started = 1'b0;
  bit prev_hr = 1'b0;
  int gap_pos = -1;
  int mc = 0, sidx = 0, nreq = 0, scnt = 0, gap_left = 0;
  int start_cnt = 0, start_cyc = -1, rsth_cyc = -1;

  initial forever begin
    @(negedge clk);
    if (!core_rst_n) begin
      mc = 0; started = 0; prev_hr = 0; sidx = 0; nreq = 0; scnt = 0; gap_left = 0;
      core_hash_ready = 1'b0;
      core_digest = 1'b0;
    end else begin
      if (mc < int'(Y)) begin
        lat[Y-1-mc] = core_msg;
        if (mc == 0) rsth_cyc = cyc;
        mc++;
      end
      core_digest = 1'b0;
      if (prev_hr) begin
        core_digest = golden[sidx];
        sidx++;
      end
      if (core_start) begin
        start_cnt++; start_cyc = cyc; started = 1; scnt = 0;
      end else if (started) begin
        scnt++;
      end
      prev_hr = 1'b0;
      if (started && respond && scnt >= 10 && nreq < int'(L)) begin
        if (gap_left > 0) gap_left--;
        else begin
          prev_hr = 1'b1;
          nreq++;
          if (nreq == gap_pos + 1) gap_left = 3;
        end
      end
      core_hash_ready = prev_hr;
    end
  end

  typedef struct {
    logic [Y-1:0] msg;
    logic [L-1:0] gold;
    int           gap;
    bit           respond;
    logic [L-1:0] exp_dig;
    bit           exp_terr;
    int           dv_off;   // cycles from core_start to digest_valid
  } vec_t;

  vec_t vecs[4];

  task automatic run_txn(input vec_t v, input string tag);
    int e0, n, dv_cyc;
    golden = v.gold; gap_pos = v.gap; respond = v.respond;
    start_cnt = 0; start_cyc = -1; rsth_cyc = -1;
    @(negedge clk);
    chk(tag, "req_ready_idle", req_ready, 1);
    msg_data = v.msg; req_valid = 1'b1;
    @(negedge clk);                         // C0
    e0 = cyc; req_valid = 1'b0;
    chk(tag, "core_rst_n_c0", core_rst_n, 0);
    @(negedge clk);                         // C1
    chk(tag, "dv_low_c1", digest_valid, 0);
    repeat (2) @(negedge clk);              // C3: request while busy must be ignored
    req_valid = 1'b1; msg_data = ~v.msg;
    repeat (2) @(negedge clk);              // C5
    chk(tag, "req_ready_busy", req_ready, 0);
    req_valid = 1'b0;
    n = 0;
    while (digest_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, "dv_seen", digest_valid, 1);
    dv_cyc = cyc;
    chk(tag, "rst_release_c1", rsth_cyc - e0, 1);
    chk(tag, "msg_latch", lat, v.msg);
    chk(tag, "start_count", start_cnt, 1);
    chk(tag, "start_cycle", start_cyc - e0, 258);
    chk(tag, "dv_latency", dv_cyc - start_cyc, v.dv_off);
    chk(tag, "digest", digest_data, v.exp_dig);
    chk(tag, "timeout_err", timeout_err, v.exp_terr);
    repeat (4) @(negedge clk);
    chk(tag, "dv_hold", digest_valid, 1);
    chk(tag, "digest_hold", digest_data, v.exp_dig);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk(tag, "dv_drop", digest_valid, 0);
    chk(tag, "req_ready_after", req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int e0, n, sc, scyc;
    vecs[0] = '{40'h80_0000_0001,
                256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_0123456789ABCDEF,
                -1, 1'b1,
                256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_0123456789ABCDEF,
                1'b0, 267};
    vecs[1] = '{40'hA5_5AC3_3C0F,
                256'hFEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_0123456789ABCDEF,
                100, 1'b1,
                256'hFEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_0123456789ABCDEF,
                1'b0, 270};
    vecs[2] = '{40'h12_3456_789A, '0, -1, 1'b0, '0, 1'b1, 51};
    vecs[3] = '{40'h00_0000_00FF,
                256'h0123456789ABCDEF_DEADBEEFCAFEF00D_5555AAAA3333CCCC_0123456789ABCDEF,
                -1, 1'b1,
                256'h0123456789ABCDEF_DEADBEEFCAFEF00D_5555AAAA3333CCCC_0123456789ABCDEF,
                1'b0, 267};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "req_ready", req_ready, 1);
    chk("reset", "digest_valid", digest_valid, 0);
    chk("reset", "core_rst_n", core_rst_n, 0);
    chk("reset", "core_msg", core_msg, 0);
    chk("reset", "core_start", core_start, 0);
    chk("reset", "digest_data", digest_data, 0);
    chk("reset", "timeout_err", timeout_err, 0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of SHIFT, then a clean transaction.
    golden = '0; respond = 1'b1; gap_pos = -1;
    @(negedge clk);
    msg_data = 40'hDE_ADBE_EF12; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);             // C20
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst", "digest_valid", digest_valid, 0);
    chk("midrst", "core_rst_n", core_rst_n, 0);
    chk("midrst", "core_msg", core_msg, 0);
    chk("midrst", "req_ready", req_ready, 1);
    chk("midrst", "digest_data", digest_data, 0);
    rst = 1'b1;
    run_txn(vecs[3], "post_rst");

    // Wide message: start strobe at C302.
    @(negedge clk);
    req_valid_b = 1'b1;
    @(negedge clk);
    e0 = cyc; req_valid_b = 1'b0;
    sc = 0; scyc = -1;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (core_start_b) begin
        sc++;
        scyc = cyc;
      end
    end
    chk("wide", "start_count", sc, 1);
    chk("wide", "start_cycle", scyc - e0, 302);
    chk("wide", "digest_valid", digest_valid_b, 1);
    chk("wide", "timeout_err", timeout_err_b, 1);
    digest_ready_b = 1'b1;
    @(negedge clk);
    digest_ready_b = 1'b0;
    chk("wide", "dv_drop", digest_valid_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
